uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter, on the same line format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), idle-high line.
- Samples an asynchronous rx line on an external oversampling tick.
- Emits each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board rx pin and the host-side byte consumer.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate, from an external divider.
- data  output  DATA_BITS  last correctly framed byte.
- data_valid  output  1  one-clk pulse when data updates.
- frame_error  output  1  one-clk pulse when the stop bit samples 0.
- parity_error  output  1  one-clk pulse on parity mismatch; constant 0 unless UART_RX_PARITY_EN.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchronizer: rx passes through 2 flops (rx_s); both reset to 1. All decisions use rx_s only.
- Progress rule: tick_cnt (log2 OVERSAMPLE bits) and state advance only on clk edges where sample_tick=1. Without ticks, the block holds state regardless of rx.
- Reset values: data=0, data_valid=0, frame_error=0, parity_error=0, busy=0, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-frame: the partial frame is discarded with no strobes; the next frame needs a fresh start edge.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: count ticks. At tick_cnt=OVERSAMPLE/2-1 (bit centre):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: treat as a glitch and return to IDLE with no strobe.
- DATA: on the tick where tick_cnt=OVERSAMPLE-1, sample rx_s into the shift register MSB, shift right, bit_cnt++, tick_cnt=0. After sample DATA_BITS, go to PARITY if the macro is defined, else STOP.
- STOP: at tick_cnt=OVERSAMPLE-1, sample rx_s.
  - 1: data <= shift register; data_valid=1 for the next clk cycle; go to IDLE.
  - 0: frame_error=1 for one cycle; data unchanged; data_valid stays 0; go to BREAK.
- BREAK: stay until a tick with rx_s=1, then go to IDLE. A held-low line therefore yields exactly one frame_error.
- Latency: strobes go high on the clk edge after the stop-centre tick edge. From the stop-bit centre on the pin, that is <= 3 clk including the synchronizer.
- Strobes: data_valid, frame_error and parity_error are never high two cycles in a row. data_valid and frame_error are never high together.
- Back-to-back frames: a start bit directly after a stop bit is accepted; IDLE detects it on the first tick with rx_s=0.
- Tick jitter: tick_cnt wraps mod OVERSAMPLE; no overflow state exists.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - At PARITY's bit centre, samples an even-parity bit: the count of ones across the data bits plus the parity bit must be even.
  - On mismatch, parity_error pulses in the same cycle as data_valid; the byte is still delivered.
  - On a framing error, parity_error is suppressed.
- Undefined: no PARITY state; parity_error tied 0; frame = 1 + DATA_BITS + 1 bits.

Test Plan:
- Bench setup for all scenarios: OVERSAMPLE=16, DATA_BITS=8, sample_tick every 4 clk.
- Nominal byte: drive 0xA5 frame at 64 clk/bit -> exactly one data_valid pulse, data=0xA5, frame_error=0, busy falls the cycle after the pulse.
- Glitch rejection: rx low for 4 ticks, then high -> no data_valid, no frame_error; busy high <= 8 ticks, then returns to 0.
- Framing error: after the 0xA5 frame, send 0x3C with stop=0 and hold rx low 200 clk -> single frame_error pulse, data stays 0xA5. A following valid 0x5A frame after rx returns high -> data=0x5A.
- Back-to-back frames: 0x00 then 0xFF with no idle gap -> two data_valid pulses 640 clk apart, values 0x00 then 0xFF.
- Reset mid-frame: assert rst for 1 clk after 3 data bits of 0x81 -> all outputs 0, no strobe for the partial frame; the next 0x81 frame is received correctly.
- Parity (UART_RX_PARITY_EN): send 0x01 with parity bit 0 -> data_valid and parity_error together, data=0x01. With parity bit 1 -> data_valid only.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop rx synchronizer, oversampled start/data/stop framing, framing-error detection.
// Optional even-parity bit between data and stop bits is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a tick with rx_s low
    // START  | counting to the start-bit centre; high there means a glitch
    // DATA   | sampling data bits at their centres, LSB first
    // PARITY | sampling the even-parity bit (UART_RX_PARITY_EN builds only)
    // STOP   | sampling the stop bit: deliver the byte or flag a framing error
    // BREAK  | line still low after a framing error, waiting for it to go high

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] TC_BITS = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

    state_t               state_q,       state_d;
    logic                 rx_meta_q,     rx_meta_d;
    logic                 rx_s_q,        rx_s_d;
    logic [TW-1:0]        tick_cnt_q,    tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,     bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,       shift_d;
    logic [DATA_BITS-1:0] data_q,        data_d;
    logic                 data_valid_q,  data_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q,        busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q,      par_bit_d;
    logic                 parity_error_q, parity_error_d;
`endif

    always_comb begin
        rx_meta_d     = rx;
        rx_s_d        = rx_meta_q;
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
        par_bit_d      = par_bit_q;
        parity_error_d = 1'b0;
`endif

        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end

                START: begin
                    if (tick_cnt_q == TC_HALF) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                // From here on every sample lands one full bit after the previous centre.
                DATA: begin
                    if (tick_cnt_q == TC_FULL) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == TC_BITS) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_q == TC_FULL) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_s_q;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`endif

                STOP: begin
                    if (tick_cnt_q == TC_FULL) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error_d = (^shift_q) ^ par_bit_q;
`endif
                            state_d      = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                BREAK: begin
                    if (rx_s_q) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q      <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q      <= par_bit_d;
            parity_error_q <= parity_error_d;
`endif
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, DATA_BITS=8, sample_tick every 4 clk, 64 clk per bit.
module tb_uart_receiver;

    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_CLK = (10 + PAR) * BIT_CLK;

    logic       clk, rst, rx, sample_tick;
    logic [7:0] data;
    logic       data_valid, frame_error, parity_error, busy;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0, dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, pe_dv_cnt = 0;
    int both_cnt = 0, double_cnt = 0, busy_cyc = 0;
    logic busy_at_dv = 1'b0;
    logic busy_after_dv = 1'b1;
    int         dv_cyc_q[$];
    logic [7:0] dv_data_q[$];

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .sample_tick(sample_tick),
        .data(data), .data_valid(data_valid), .frame_error(frame_error),
        .parity_error(parity_error), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : tick_gen
        int tdiv;
        tdiv = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            sample_tick = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    initial begin : monitor
        logic dv_prev, fe_prev, pe_prev;
        dv_prev = 1'b0; fe_prev = 1'b0; pe_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cyc++;
            if (dv_prev) busy_after_dv = busy;
            if (data_valid === 1'b1) begin
                dv_cnt++;
                busy_at_dv = busy;
                dv_cyc_q.push_back(cyc);
                dv_data_q.push_back(data);
                if (parity_error === 1'b1) pe_dv_cnt++;
            end
            if (frame_error === 1'b1) fe_cnt++;
            if (parity_error === 1'b1) pe_cnt++;
            if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
            if ((data_valid === 1'b1 && dv_prev) || (frame_error === 1'b1 && fe_prev) ||
                (parity_error === 1'b1 && pe_prev)) double_cnt++;
            dv_prev = (data_valid === 1'b1);
            fe_prev = (frame_error === 1'b1);
            pe_prev = (parity_error === 1'b1);
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // par_flip=1 sends a deliberately wrong parity bit (parity builds only).
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR != 0) drive_bit((^b) ^ par_flip);
        drive_bit(stop_v);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", data); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        n_vec++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b expected 0", frame_error); end
        n_vec++; if (parity_error !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b expected 0", parity_error); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_nominal;
        int dv0, fe0, st, lat;
        dv0 = dv_cnt; fe0 = fe_cnt; st = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 1) begin n_err++; $display("FAIL nominal_dv_count: got %0d expected 1", dv_cnt - dv0); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL nominal_data: got %h expected a5", data); end
        n_vec++; if (fe_cnt - fe0 != 0) begin n_err++; $display("FAIL nominal_fe: got %0d expected 0", fe_cnt - fe0); end
        n_vec++; if (busy_at_dv !== 1'b1) begin n_err++; $display("FAIL nominal_busy_at_dv: got %b expected 1", busy_at_dv); end
        n_vec++; if (busy_after_dv !== 1'b0) begin n_err++; $display("FAIL nominal_busy_after_dv: got %b expected 0", busy_after_dv); end
        lat = (dv_cyc_q.size() > 0) ? dv_cyc_q[dv_cyc_q.size()-1] - st : -1;
        n_vec++;
        if (lat < 605 + PAR * BIT_CLK || lat > 625 + PAR * BIT_CLK) begin
            n_err++; $display("FAIL nominal_latency: got %0d expected %0d..%0d", lat, 605 + PAR * BIT_CLK, 625 + PAR * BIT_CLK);
        end
    endtask

    task automatic test_glitch;
        int dv0, fe0, b0, bc;
        dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cyc;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        bc = busy_cyc - b0;
        n_vec++; if (dv_cnt - dv0 != 0) begin n_err++; $display("FAIL glitch_dv: got %0d expected 0", dv_cnt - dv0); end
        n_vec++; if (fe_cnt - fe0 != 0) begin n_err++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - fe0); end
        n_vec++; if (bc < 1 || bc > 32) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d expected 1..32", bc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_framing;
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL framing_busy_break: got %b expected 1", busy); end
        rx = 1'b1;
        repeat (128) @(negedge clk);
        n_vec++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL framing_fe_count: got %0d expected 1", fe_cnt - fe0); end
        n_vec++; if (dv_cnt - dv0 != 0) begin n_err++; $display("FAIL framing_dv_count: got %0d expected 0", dv_cnt - dv0); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL framing_data_held: got %h expected a5", data); end
        dv0 = dv_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 1) begin n_err++; $display("FAIL recover_dv_count: got %0d expected 1", dv_cnt - dv0); end
        n_vec++; if (data !== 8'h5A) begin n_err++; $display("FAIL recover_data: got %h expected 5a", data); end
    endtask

    task automatic test_back_to_back;
        int dv0, n0, gap;
        logic [7:0] d0, d1;
        dv0 = dv_cnt; n0 = dv_cyc_q.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 2) begin n_err++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0); end
        d0 = 8'hXX; d1 = 8'hXX; gap = -1;
        if (dv_cyc_q.size() >= n0 + 2) begin
            d0 = dv_data_q[n0]; d1 = dv_data_q[n0+1];
            gap = dv_cyc_q[n0+1] - dv_cyc_q[n0];
        end
        n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h expected 00", d0); end
        n_vec++; if (d1 !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h expected ff", d1); end
        n_vec++; if (gap != FRAME_CLK) begin n_err++; $display("FAIL b2b_gap: got %0d expected %0d", gap, FRAME_CLK); end
    endtask

    task automatic test_reset_mid;
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h expected 00", data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_vec++; if (data_valid !== 1'b0 || frame_error !== 1'b0 || parity_error !== 1'b0) begin
            n_err++; $display("FAIL rstmid_strobes: got %b%b%b expected 000", data_valid, frame_error, parity_error);
        end
        repeat (700) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 0 || fe_cnt - fe0 != 0) begin
            n_err++; $display("FAIL rstmid_no_strobe: got dv %0d fe %0d expected 0 0", dv_cnt - dv0, fe_cnt - fe0);
        end
        dv0 = dv_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 1) begin n_err++; $display("FAIL rstmid_next_dv: got %0d expected 1", dv_cnt - dv0); end
        n_vec++; if (data !== 8'h81) begin n_err++; $display("FAIL rstmid_next_data: got %h expected 81", data); end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        int dv0, pe0, pdv0;
        dv0 = dv_cnt; pe0 = pe_cnt; pdv0 = pe_dv_cnt;
        send_frame(8'h01, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 1) begin n_err++; $display("FAIL par_bad_dv: got %0d expected 1", dv_cnt - dv0); end
        n_vec++; if (pe_dv_cnt - pdv0 != 1 || pe_cnt - pe0 != 1) begin
            n_err++; $display("FAIL par_bad_pe: got %0d with dv, %0d total expected 1 1", pe_dv_cnt - pdv0, pe_cnt - pe0);
        end
        n_vec++; if (data !== 8'h01) begin n_err++; $display("FAIL par_bad_data: got %h expected 01", data); end
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h01, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (dv_cnt - dv0 != 1) begin n_err++; $display("FAIL par_good_dv: got %0d expected 1", dv_cnt - dv0); end
        n_vec++; if (pe_cnt - pe0 != 0) begin n_err++; $display("FAIL par_good_pe: got %0d expected 0", pe_cnt - pe0); end
`else
        n_vec++; if (pe_cnt != 0) begin n_err++; $display("FAIL par_disabled_pe: got %0d expected 0", pe_cnt); end
`endif
    endtask

    task automatic test_strobe_rules;
        n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL strobe_dv_fe_together: got %0d expected 0", both_cnt); end
        n_vec++; if (double_cnt != 0) begin n_err++; $display("FAIL strobe_two_cycles: got %0d expected 0", double_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        test_strobe_rules();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
